// File: rtl/traffic_arbiter.sv
// Two-street intersection arbiter: six-state light sequencer with a saturating
// dwell counter, minimum/maximum green times and a Mealy change strobe.
module traffic_arbiter #(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 12,
   parameter int YELLOW_T  = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a,
   input  logic       b,
   output logic [1:0] la,
   output logic [1:0] lb,
   output logic [2:0] st,
   output logic       chg
);

   localparam int unsigned CW = 4;

   localparam logic [2:0] S_A_GREEN  = 3'd0;
   localparam logic [2:0] S_A_YELLOW = 3'd1;
   localparam logic [2:0] S_RED_AB   = 3'd2;
   localparam logic [2:0] S_B_GREEN  = 3'd3;
   localparam logic [2:0] S_B_YELLOW = 3'd4;
   localparam logic [2:0] S_RED_BA   = 3'd5;

   localparam logic [1:0] L_GREEN  = 2'b00;
   localparam logic [1:0] L_YELLOW = 2'b01;
   localparam logic [1:0] L_RED    = 2'b10;

   localparam logic [CW-1:0] G_MIN_M1 = CW'(GREEN_MIN - 1);
   localparam logic [CW-1:0] G_MAX_M1 = CW'(GREEN_MAX - 1);
   localparam logic [CW-1:0] Y_M1     = CW'(YELLOW_T - 1);
   localparam logic [CW-1:0] CNT_SAT  = CW'(15);

   logic [2:0]    state;
   logic [2:0]    state_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic [1:0]    la_nx;
   logic [1:0]    lb_nx;

   logic min_ok;
   logic max_hit;
   logic yellow_done;

   assign min_ok      = (cnt >= G_MIN_M1);
   assign max_hit     = (cnt >= G_MAX_M1);
   assign yellow_done = (cnt == Y_M1);

   // State, dwell counter and registered Moore outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_A_GREEN;
         cnt   <= '0;
         la    <= L_GREEN;
         lb    <= L_RED;
         st    <= S_A_GREEN;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         la    <= la_nx;
         lb    <= lb_nx;
         st    <= state_nx;
      end
   end

   // Next state, Mealy change strobe and next-cycle light decode
   always_comb begin
      state_nx = state;
      chg      = 1'b0;
      la_nx    = L_RED;
      lb_nx    = L_RED;

      case (state)
         S_A_GREEN: begin
            if (min_ok && b && (!a || max_hit)) begin
               chg      = 1'b1;
               state_nx = S_A_YELLOW;
            end
         end
         S_A_YELLOW: if (yellow_done) state_nx = S_RED_AB;
         S_RED_AB:   state_nx = S_B_GREEN;
         S_B_GREEN: begin
            if (min_ok && a && (!b || max_hit)) begin
               chg      = 1'b1;
               state_nx = S_B_YELLOW;
            end
         end
         S_B_YELLOW: if (yellow_done) state_nx = S_RED_BA;
         S_RED_BA:   state_nx = S_A_GREEN;
         default:    state_nx = S_A_GREEN;
      endcase

      // Strobe must never be seen while reset holds the sequencer
      if (!reset) chg = 1'b0;

      case (state_nx)
         S_A_GREEN:  la_nx = L_GREEN;
         S_A_YELLOW: la_nx = L_YELLOW;
         S_B_GREEN:  lb_nx = L_GREEN;
         S_B_YELLOW: lb_nx = L_YELLOW;
         default: begin
            la_nx = L_RED;
            lb_nx = L_RED;
         end
      endcase

      if (state_nx != state)   cnt_nx = '0;
      else if (cnt == CNT_SAT) cnt_nx = cnt;
      else                     cnt_nx = cnt + CW'(1);
   end

endmodule

// File: tb/tb_traffic_arbiter.sv
// Directed self-checking bench for traffic_arbiter with default parameters.
module tb_traffic_arbiter;

   logic       clk;
   logic       reset;
   logic       a;
   logic       b;
   logic [1:0] la;
   logic [1:0] lb;
   logic [2:0] st;
   logic       chg;

   int total = 0;
   int bad   = 0;

   logic [2:0] seq_st  [9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3};
   logic       seq_chg [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [2:0] ret_st  [8] = '{3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0};
   logic       ret_chg [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   traffic_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .la    (la),
      .lb    (lb),
      .st    (st),
      .chg   (chg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [1:0] exp_la(input logic [2:0] s);
      case (s)
         3'd0:    return 2'b00;
         3'd1:    return 2'b01;
         default: return 2'b10;
      endcase
   endfunction

   function automatic logic [1:0] exp_lb(input logic [2:0] s);
      case (s)
         3'd3:    return 2'b00;
         3'd4:    return 2'b01;
         default: return 2'b10;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total = total + 1;
      assert (obs === exp)
      else begin
         bad = bad + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [2:0] e_st, input logic e_chg);
      chk({tag, ".st"},  4'(st),  4'(e_st));
      chk({tag, ".la"},  4'(la),  4'(exp_la(e_st)));
      chk({tag, ".lb"},  4'(lb),  4'(exp_lb(e_st)));
      chk({tag, ".chg"}, 4'(chg), 4'(e_chg));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      a     = 1'b0;
      b     = 1'b1;

      // Reset values, then b-only request walks A green -> yellow -> red -> B green
      #12;
      chk_state("reset", 3'd0, 1'b0);
      reset = 1'b1;
      chk_state("a2b_c1", seq_st[0], seq_chg[0]);
      for (int k = 1; k < 9; k++) begin
         tick();
         chk_state($sformatf("a2b_c%0d", k + 1), seq_st[k], seq_chg[k]);
      end

      // In B green at cnt=0, swap requests: back to A green after min dwell
      a = 1'b1;
      b = 1'b0;
      #1;
      chk_state("b2a_c0", 3'd3, 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk_state($sformatf("b2a_c%0d", k + 1), ret_st[k], ret_chg[k]);
      end

      // Idle: A green held, counter must saturate rather than wrap
      a = 1'b0;
      b = 1'b0;
      for (int k = 0; k < 32; k++) begin
         tick();
         chk_state($sformatf("idle_c%0d", k), 3'd0, 1'b0);
      end
      b = 1'b1;
      #1;
      chk_state("sat_chg", 3'd0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_state($sformatf("sat_seq%0d", k), (k < 3) ? 3'd1 : ((k == 3) ? 3'd2 : 3'd3), 1'b0);
      end

      // Walk into B yellow, then reset asynchronously in its second cycle
      a = 1'b1;
      b = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_state($sformatf("by_c%0d", k), (k < 3) ? 3'd3 : 3'd4, (k == 2) ? 1'b1 : 1'b0);
      end
      #2;
      reset = 1'b0;
      #1;
      chk_state("async_rst", 3'd0, 1'b0);

      // Short b pulse at cnt=1 must not be latched
      a = 1'b0;
      b = 1'b0;
      #3;
      reset = 1'b1;
      tick();
      b = 1'b1;
      #1;
      chk_state("pulse_c1", 3'd0, 1'b0);
      tick();
      b = 1'b0;
      #1;
      chk_state("pulse_c2", 3'd0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk_state($sformatf("pulse_hold%0d", k), 3'd0, 1'b0);
      end

      // Both requesting: alternate every GREEN_MAX, lights never both non-red
      reset = 1'b0;
      #3;
      chk_state("rst2", 3'd0, 1'b0);
      a = 1'b1;
      b = 1'b1;
      reset = 1'b1;
      for (int k = 0; k < 64; k++) begin
         int p;
         logic [2:0] es;
         p = k % 32;
         if (p < 12)       es = 3'd0;
         else if (p < 15)  es = 3'd1;
         else if (p == 15) es = 3'd2;
         else if (p < 28)  es = 3'd3;
         else if (p < 31)  es = 3'd4;
         else              es = 3'd5;
         if (k > 0) tick();
         chk_state($sformatf("both_c%0d", k), es, (p == 11 || p == 27) ? 1'b1 : 1'b0);
         chk($sformatf("both_safe%0d", k), 4'(la == 2'b10 || lb == 2'b10), 4'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/traffic_arbiter.md
TRAFFIC_ARBITER -- requirements
Module: traffic_arbiter

Interface
REQ-001 Parameter GREEN_MIN, default 4: minimum green dwell in cycles.
REQ-002 Parameter GREEN_MAX, default 12: maximum green dwell in cycles while the opposing street requests.
REQ-003 Parameter YELLOW_T, default 3: yellow dwell in cycles.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 a  input  1  street A car-present sensor, sampled on the rising edge of clk.
REQ-007 b  input  1  street B car-present sensor, sampled on the rising edge of clk.
REQ-008 la  output  2  street A light: 00 green, 01 yellow, 10 red.
REQ-009 lb  output  2  street B light, same encoding as la.
REQ-010 st  output  3  current state code, per REQ-013.
REQ-011 chg  output  1  Mealy output: combinationally high in the cycle the green-to-yellow transition condition is true.

Function
REQ-012 The block shall arbitrate one intersection between requesters A and B with a 6-state FSM plus a dwell counter cnt.
REQ-013 State codes: A_GREEN=0, A_YELLOW=1, RED_AB=2, B_GREEN=3, B_YELLOW=4, RED_BA=5; codes 6-7 shall go to A_GREEN on the next edge.
REQ-014 Lights: A_GREEN la=00 lb=10; A_YELLOW la=01 lb=10; RED_AB, RED_BA la=10 lb=10; B_GREEN la=10 lb=00; B_YELLOW la=10 lb=01.
REQ-015 Lights and st shall be Moore outputs, decoded from the state register only.
REQ-016 cnt, 4 bits, shall be 0 on the first cycle of every state, increment by 1 on each edge that stays in the state, and saturate at 15.
REQ-017 The A_GREEN exit condition shall be: cnt >= GREEN_MIN-1 AND b=1 AND (a=0 OR cnt >= GREEN_MAX-1).
REQ-018 The B_GREEN exit condition shall mirror REQ-017 with a and b swapped.
REQ-019 When the exit condition is true, chg shall be 1 and the next state shall be the matching yellow state; otherwise chg=0 and the green state is held.
REQ-020 A yellow state shall last exactly YELLOW_T cycles (exit when cnt = YELLOW_T-1) and shall go to the following all-red state regardless of sensors.
REQ-021 An all-red state shall last exactly 1 cycle: RED_AB -> B_GREEN, RED_BA -> A_GREEN.
REQ-022 If neither street requests, the current green shall be held indefinitely, with cnt saturated at 15.
REQ-023 Requests shall not be latched: a b pulse that is low again before cnt >= GREEN_MIN-1 shall cause no switch.
REQ-024 If both a and b are held high, greens shall alternate every GREEN_MAX cycles.
REQ-025 The two lights shall never both be non-red in any cycle.
REQ-026 chg shall be 0 in all yellow and all-red states.

Reset
REQ-027 reset=0 shall force, asynchronously and independent of clk: state=A_GREEN, cnt=0, la=00, lb=10, st=000, chg=0.
REQ-028 Reset asserted mid-sequence (including during yellow or all-red) shall abort the sequence immediately with no intermediate light values.
REQ-029 After reset deasserts, the first rising edge shall be counted as an A_GREEN cycle with cnt advancing 0 -> 1.

Verification
REQ-030 Release reset with a=0, b=1 -> la=00 for 4 cycles (chg=1 at cnt=3), la=01 for 3 cycles, both red for 1 cycle, then lb=00 from the 9th cycle.
REQ-031 Hold a=1, b=1 continuously -> A green for 12 cycles, yellow 3, red 1, B green 12, repeating; la and lb are never both non-red.
REQ-032 Hold a=0, b=0 for 30 cycles -> la=00 and chg=0 throughout; cnt saturates at 15 with no transition.
REQ-033 Pulse b=1 for one cycle at cnt=1 in A_GREEN, a=0 -> no transition; A_GREEN is held.
REQ-034 Assert reset in the 2nd cycle of B_YELLOW -> la=00, lb=10, st=000 immediately, before the next clk edge.
REQ-035 With B_GREEN active, set b=0 and a=1 at cnt=0 -> chg=1 at cnt=3, then B_YELLOW, RED_BA, and A_GREEN after 3+1 cycles.
